branch_resolve_unit: RTL and testbench

- Consumer end of the branch-prediction path.
- Carries each IF-stage prediction (hit, predicted PC) alongside its instruction through the ID and EX pipeline registers.
- At EX, compares the prediction with the resolved branch outcome and drives the predictor update bus (branch_ex, branch_hit_ex, PCE, BrNPCE).
- Raises a mispredict redirect to the PC mux and hazard unit, and keeps branch/mispredict performance counters.

---
 rtl/bp_pkg.sv | 24 ++
 rtl/pred_pipe_reg.sv | 23 ++
 rtl/branch_resolve_unit.sv | 103 ++++++++++
 tb/tb_branch_resolve_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared branch-prediction types: the prediction record that travels down the
// pipeline alongside each instruction, plus the sequential PC step.
package bp_pkg;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic        hit;
      logic [31:0] target;
   } pred_info_t;

   localparam logic [31:0] PC_INC = 32'd4;

   // Empty slot: no instruction, no prediction, PCs parked at the reset value.
   function automatic pred_info_t pred_bubble(input logic [31:0] park_pc);
      pred_info_t b;
      b.valid  = 1'b0;
      b.pc     = park_pc;
      b.hit    = 1'b0;
      b.target = park_pc;
      return b;
   endfunction

endpackage

// File: rtl/pred_pipe_reg.sv
// One pipeline stage of prediction info; reset beats flush, flush beats stall.
module pred_pipe_reg
   import bp_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       stall,
   input  logic       flush,
   input  pred_info_t d,
   output pred_info_t q
);

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         q <= pred_bubble(RESET_PC);
      end else if (!stall) begin
         q <= d;
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Carries IF predictions through ID/EX, resolves them against the EX outcome,
// drives the predictor update bus, redirects on mispredict and counts events.
module branch_resolve_unit
   import bp_pkg::*;
#(
   parameter int          CNT_W    = 32,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      PCF,
   input  logic             pred_hitF,
   input  logic [31:0]      pred_pcF,
   input  logic             stallD,
   input  logic             flushD,
   input  logic             stallE,
   input  logic             flushE,
   input  logic             is_branchE,
   input  logic             br_takenE,
   input  logic [31:0]      br_targetE,
   output logic             branch_ex,
   output logic             branch_hit_ex,
   output logic [31:0]      PCE,
   output logic [31:0]      BrNPCE,
   output logic             mispredictE,
   output logic [31:0]      redirect_pc,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);

   pred_info_t  f_info;
   pred_info_t  id_q;
   pred_info_t  ex_d;
   pred_info_t  ex_q;

   logic        actual_taken;
   logic [31:0] seq_pc;
   logic [31:0] actual_npc;
   logic [31:0] pred_npc;
   logic        mispredict;
   logic        update;

   always_comb begin
      f_info.valid  = 1'b1;
      f_info.pc     = PCF;
      f_info.hit    = pred_hitF;
      f_info.target = pred_pcF;
   end

   // ID held while EX drains: EX must take a bubble, not a duplicate.
   assign ex_d = stallD ? pred_bubble(RESET_PC) : id_q;

   pred_pipe_reg #(.RESET_PC(RESET_PC)) u_id_reg (
      .clk   (clk),
      .rst   (rst),
      .stall (stallD),
      .flush (flushD || mispredict),
      .d     (f_info),
      .q     (id_q)
   );

   pred_pipe_reg #(.RESET_PC(RESET_PC)) u_ex_reg (
      .clk   (clk),
      .rst   (rst),
      .stall (stallE),
      .flush (flushE || mispredict),
      .d     (ex_d),
      .q     (ex_q)
   );

   always_comb begin
      actual_taken = is_branchE && br_takenE;
      seq_pc       = ex_q.pc + PC_INC;
      actual_npc   = actual_taken ? br_targetE : seq_pc;
      pred_npc     = ex_q.hit ? ex_q.target : seq_pc;
      mispredict   = ex_q.valid && (pred_npc != actual_npc);
      update       = ex_q.valid && is_branchE;
   end

   assign mispredictE   = mispredict;
   assign redirect_pc   = mispredict ? actual_npc : 32'h0;
   assign branch_ex     = update;
   assign branch_hit_ex = update && br_takenE;
   assign PCE           = update ? ex_q.pc : 32'h0;
   assign BrNPCE        = update ? br_targetE : 32'h0;

   // Counting only on the cycle EX advances keeps a stalled branch from
   // being counted once per stall cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         branch_cnt  <= '0;
         mispred_cnt <= '0;
      end else if (ex_q.valid && !stallE) begin
         if (update) begin
            branch_cnt <= branch_cnt + CNT_W'(1);
         end
         if (mispredict) begin
            mispred_cnt <= mispred_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a slot-level reference model
// compared every cycle, plus literal expectations for the key scenarios.
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] PCF;
   logic        pred_hitF;
   logic [31:0] pred_pcF;
   logic        stallD, flushD, stallE, flushE;
   logic        is_branchE, br_takenE;
   logic [31:0] br_targetE;

   logic        branch_ex, branch_hit_ex, mispredictE;
   logic [31:0] PCE, BrNPCE, redirect_pc;
   logic [31:0] branch_cnt, mispred_cnt;

   logic        branch_ex_4, branch_hit_ex_4, mispredictE_4;
   logic [31:0] PCE_4, BrNPCE_4, redirect_pc_4;
   logic [3:0]  branch_cnt_4, mispred_cnt_4;

   always #5 clk = ~clk;

   branch_resolve_unit #(.CNT_W(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst), .PCF(PCF), .pred_hitF(pred_hitF), .pred_pcF(pred_pcF),
      .stallD(stallD), .flushD(flushD), .stallE(stallE), .flushE(flushE),
      .is_branchE(is_branchE), .br_takenE(br_takenE), .br_targetE(br_targetE),
      .branch_ex(branch_ex), .branch_hit_ex(branch_hit_ex), .PCE(PCE), .BrNPCE(BrNPCE),
      .mispredictE(mispredictE), .redirect_pc(redirect_pc),
      .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
   );

   branch_resolve_unit #(.CNT_W(4), .RESET_PC(32'h0)) dut4 (
      .clk(clk), .rst(rst), .PCF(PCF), .pred_hitF(pred_hitF), .pred_pcF(pred_pcF),
      .stallD(stallD), .flushD(flushD), .stallE(stallE), .flushE(flushE),
      .is_branchE(is_branchE), .br_takenE(br_takenE), .br_targetE(br_targetE),
      .branch_ex(branch_ex_4), .branch_hit_ex(branch_hit_ex_4), .PCE(PCE_4), .BrNPCE(BrNPCE_4),
      .mispredictE(mispredictE_4), .redirect_pc(redirect_pc_4),
      .branch_cnt(branch_cnt_4), .mispred_cnt(mispred_cnt_4)
   );

   // Reference model: one record per pipeline slot.
   typedef struct {
      bit        v;
      bit [31:0] pc;
      bit        hit;
      bit [31:0] tgt;
   } slot_t;

   slot_t     m_id, m_ex;
   bit [31:0] m_bcnt, m_mcnt;
   bit [3:0]  m_bcnt4, m_mcnt4;
   int        vectors = 0;
   int        miscompares = 0;
   bit        cmp_en = 1'b0;

   function automatic bit [31:0] m_actual();
      return (is_branchE && br_takenE) ? br_targetE : m_ex.pc + 32'd4;
   endfunction

   function automatic bit m_mis();
      bit [31:0] guess;
      guess = m_ex.hit ? m_ex.tgt : m_ex.pc + 32'd4;
      return m_ex.v && (guess != m_actual());
   endfunction

   function automatic bit m_upd();
      return m_ex.v && is_branchE;
   endfunction

   always @(posedge clk) begin
      slot_t empty;
      bit    mis_now, upd_now;
      empty = '{1'b0, 32'h0, 1'b0, 32'h0};
      if (rst) begin
         m_id = empty; m_ex = empty;
         m_bcnt = 0; m_mcnt = 0; m_bcnt4 = 0; m_mcnt4 = 0;
      end else begin
         mis_now = m_mis();
         upd_now = m_upd();
         if (m_ex.v && !stallE) begin
            m_bcnt  = m_bcnt  + 32'(upd_now);
            m_mcnt  = m_mcnt  + 32'(mis_now);
            m_bcnt4 = m_bcnt4 + 4'(upd_now);
            m_mcnt4 = m_mcnt4 + 4'(mis_now);
         end
         if (flushE || mis_now) m_ex = empty;
         else if (!stallE)      m_ex = stallD ? empty : m_id;
         if (flushD || mis_now) m_id = empty;
         else if (!stallD)      m_id = '{1'b1, PCF, pred_hitF, pred_pcF};
      end
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      cmp(name, act, exp);
   endtask

   always @(negedge clk) begin
      bit        e_mis, e_upd;
      bit [31:0] e_red, e_pc, e_npc;
      if (cmp_en) begin
         vectors++;
         e_mis = m_mis();
         e_upd = m_upd();
         e_red = e_mis ? m_actual() : 32'h0;
         e_pc  = e_upd ? m_ex.pc : 32'h0;
         e_npc = e_upd ? br_targetE : 32'h0;
         cmp("model.mispredictE",   mispredictE,   e_mis);
         cmp("model.redirect_pc",   redirect_pc,   e_red);
         cmp("model.branch_ex",     branch_ex,     e_upd);
         cmp("model.branch_hit_ex", branch_hit_ex, e_upd && br_takenE);
         cmp("model.PCE",           PCE,           e_pc);
         cmp("model.BrNPCE",        BrNPCE,        e_npc);
         cmp("model.branch_cnt",    branch_cnt,    m_bcnt);
         cmp("model.mispred_cnt",   mispred_cnt,   m_mcnt);
         cmp("model4.mispredictE",  mispredictE_4, e_mis);
         cmp("model4.redirect_pc",  redirect_pc_4, e_red);
         cmp("model4.branch_ex",    branch_ex_4,   e_upd);
         cmp("model4.branch_hit",   branch_hit_ex_4, e_upd && br_takenE);
         cmp("model4.PCE",          PCE_4,         e_pc);
         cmp("model4.BrNPCE",       BrNPCE_4,      e_npc);
         cmp("model4.branch_cnt",   branch_cnt_4,  m_bcnt4);
         cmp("model4.mispred_cnt",  mispred_cnt_4, m_mcnt4);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic fetch(input logic [31:0] pc, input logic hit, input logic [31:0] tgt);
      PCF = pc; pred_hitF = hit; pred_pcF = tgt;
   endtask

   task automatic idle_ex();
      is_branchE = 1'b0; br_takenE = 1'b0; br_targetE = 32'h0;
   endtask

   // Fetch one instruction, let it reach EX two cycles later, resolve it there.
   task automatic run_branch(input string name, input logic [31:0] pc, input logic hit,
                             input logic [31:0] ptgt, input logic isb, input logic tk,
                             input logic [31:0] btgt, input logic exp_mis,
                             input logic [31:0] exp_red);
      fetch(pc, hit, ptgt); idle_ex(); tick();
      fetch(pc + 32'd4, 1'b0, 32'h0); tick();
      fetch(pc + 32'd8, 1'b0, 32'h0);
      is_branchE = isb; br_takenE = tk; br_targetE = btgt;
      settle();
      check({name, ".mispredictE"},   mispredictE,   exp_mis);
      check({name, ".redirect_pc"},   redirect_pc,   exp_red);
      check({name, ".branch_ex"},     branch_ex,     isb);
      check({name, ".branch_hit_ex"}, branch_hit_ex, isb && tk);
      check({name, ".PCE"},           PCE,           isb ? pc : 32'h0);
      tick();
      idle_ex();
   endtask

   initial begin
      #200000;
      miscompares++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      stallD = 1'b0; flushD = 1'b0; stallE = 1'b0; flushE = 1'b0;
      fetch(32'h0, 1'b0, 32'h0); idle_ex();
      tick();
      cmp_en = 1'b1;
      tick();
      rst = 1'b0;
      settle();
      check("reset.branch_ex",   branch_ex,   0);
      check("reset.mispredictE", mispredictE, 0);
      check("reset.redirect_pc", redirect_pc, 0);
      check("reset.PCE",         PCE,         0);
      check("reset.branch_cnt",  branch_cnt,  0);
      check("reset.mispred_cnt", mispred_cnt, 0);
      tick();

      run_branch("pred_taken_ok", 32'h100, 1'b1, 32'h140, 1'b1, 1'b1, 32'h140, 1'b0, 32'h0);
      settle();
      check("pred_taken_ok.branch_cnt",  branch_cnt,  1);
      check("pred_taken_ok.mispred_cnt", mispred_cnt, 0);

      run_branch("nt_but_taken", 32'h200, 1'b0, 32'h0, 1'b1, 1'b1, 32'h180, 1'b1, 32'h180);
      // Squashed slots must stay silent even with branch inputs asserted.
      fetch(32'h250, 1'b0, 32'h0);
      is_branchE = 1'b1; br_takenE = 1'b1; br_targetE = 32'h999;
      settle();
      check("squash.validE", branch_ex, 0);
      check("squash.mispred_cnt", mispred_cnt, 1);
      check("squash.branch_cnt", branch_cnt, 2);
      tick();
      settle();
      check("squash.validD", branch_ex, 0);
      tick();
      idle_ex();

      run_branch("taken_but_nt", 32'h300, 1'b1, 32'h340, 1'b1, 1'b0, 32'h340, 1'b1, 32'h304);
      run_branch("wrong_target", 32'h3C0, 1'b1, 32'h400, 1'b1, 1'b1, 32'h480, 1'b1, 32'h480);
      run_branch("nonbr_alias",  32'h500, 1'b1, 32'h540, 1'b0, 1'b0, 32'h0,   1'b1, 32'h504);
      run_branch("pc_wrap",      32'hFFFFFFFC, 1'b1, 32'h1000, 1'b1, 1'b0, 32'h2000, 1'b1, 32'h0);
      settle();
      check("mix.branch_cnt",  branch_cnt,  5);
      check("mix.mispred_cnt", mispred_cnt, 5);
      tick();

      fetch(32'h600, 1'b1, 32'h640); tick();
      fetch(32'h604, 1'b0, 32'h0); tick();
      fetch(32'h608, 1'b0, 32'h0);
      is_branchE = 1'b1; br_takenE = 1'b1; br_targetE = 32'h640;
      stallD = 1'b1; stallE = 1'b1;
      for (int i = 0; i < 3; i++) begin
         settle();
         check("stall.branch_ex", branch_ex, 1);
         check("stall.PCE", PCE, 32'h600);
         tick();
      end
      stallD = 1'b0; stallE = 1'b0;
      settle();
      check("stall.cnt_held", branch_cnt, 5);
      tick();
      idle_ex();
      settle();
      check("stall.cnt_once", branch_cnt, 6);
      tick();
      tick();
      settle();
      check("stall.cnt_after", branch_cnt, 6);
      tick();

      fetch(32'h700, 1'b0, 32'h0); tick();
      fetch(32'h704, 1'b0, 32'h0); tick();
      fetch(32'h708, 1'b0, 32'h0);
      is_branchE = 1'b1; br_takenE = 1'b1; br_targetE = 32'h780;
      stallD = 1'b1; rst = 1'b1;
      settle();
      check("rst_mid.mispredictE", mispredictE, 1);
      check("rst_mid.redirect_pc", redirect_pc, 32'h780);
      tick();
      rst = 1'b0; stallD = 1'b0;
      settle();
      check("rst_mid.mispredictE_after", mispredictE, 0);
      check("rst_mid.branch_ex",   branch_ex,   0);
      check("rst_mid.PCE",         PCE,         0);
      check("rst_mid.BrNPCE",      BrNPCE,      0);
      check("rst_mid.redirect_pc_after", redirect_pc, 0);
      check("rst_mid.branch_cnt",  branch_cnt,  0);
      check("rst_mid.mispred_cnt", mispred_cnt, 0);
      check("rst_mid.branch_cnt4", branch_cnt_4, 0);
      tick();
      idle_ex();

      for (int i = 0; i < 16; i++) begin
         run_branch("wrap_loop", 32'h800 + 32'(i) * 32'h10, 1'b0, 32'h0,
                    1'b1, 1'b0, 32'h900, 1'b0, 32'h0);
      end
      settle();
      check("wrap.branch_cnt4",  branch_cnt_4, 0);
      check("wrap.branch_cnt32", branch_cnt,   16);
      check("wrap.mispred_cnt",  mispred_cnt,  0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
